// File: rtl/knn_ctrl_if.sv
// Dataset RAM read port between the KNN sequencer (master) and the point memory (slave).
// Read data is {label, y, x} and arrives one cycle after mem_ren.
interface knn_ctrl_if #(
  parameter int W     = 32,
  parameter int A_W   = 8,
  parameter int LBL_W = 8
);
  logic                 mem_ren;
  logic [A_W-1:0]       mem_addr;
  logic [W+LBL_W-1:0]   mem_rdata;

  modport master (output mem_ren, mem_addr, input mem_rdata);
  modport slave  (input mem_ren, mem_addr, output mem_rdata);
endinterface

// File: rtl/knn_ctrl.sv
// KNN search sequencer: walks the labelled 2-D point set, computes squared distance
// to the test point and keeps a sorted list of the K nearest entries.
//
// state  | meaning
// IDLE   | waiting for start; results held stable
// FETCH  | read request for point idx on the dataset port
// LOAD   | read data valid; distance and label captured
// INSERT | one-cycle parallel compare/shift into the sorted list
// FIN    | done pulse, back to IDLE
module knn_ctrl #(
  parameter int W     = 32,
  parameter int K     = 4,
  parameter int A_W   = 8,
  parameter int LBL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [W/2-1:0]    test_x,
  input  logic signed [W/2-1:0]    test_y,
  input  logic [A_W:0]             n_points,
  knn_ctrl_if.master               mem,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               nbr_cnt,
  output logic [K*(W+1)-1:0]       nbr_dist,
  output logic [K*LBL_W-1:0]       nbr_label
);

  localparam int H = W / 2;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, INSERT, FIN} state_t;

  state_t                state;
  logic signed [H-1:0]   tx_q, ty_q;
  logic [A_W:0]          npts_q;
  logic [A_W-1:0]        idx;
  logic [W:0]            d_reg;
  logic [LBL_W-1:0]      l_reg;
  logic [W:0]            dist_q [K];
  logic [LBL_W-1:0]      lbl_q  [K];

  logic signed [H-1:0]   px, py;
  logic [LBL_W-1:0]      plbl;
  logic [W:0]            dist_calc;

  assign {plbl, py, px} = mem.mem_rdata;

  // |a-b| always fits in H bits, so the square is exact in W bits
  function automatic logic [W-1:0] sq_diff(input logic signed [H-1:0] a,
                                           input logic signed [H-1:0] b);
    logic signed [H:0] diff;
    logic [H-1:0]      mag;
    logic [W-1:0]      m;
    diff = $signed({a[H-1], a}) - $signed({b[H-1], b});
    mag  = diff[H] ? H'(-diff) : diff[H-1:0];
    m    = {{(W-H){1'b0}}, mag};
    return m * m;
  endfunction

  assign dist_calc = {1'b0, sq_diff(px, tx_q)} + {1'b0, sq_diff(py, ty_q)};

  logic [K-1:0]      le;
  logic [W:0]        ins_d [K];
  logic [LBL_W-1:0]  ins_l [K];

  // le is a prefix mask on the sorted list; the new entry lands after all entries <= it
  always_comb begin
    for (int i = 0; i < K; i++) begin
      le[i] = (dist_q[i] <= d_reg);
    end
    ins_d[0] = le[0] ? dist_q[0] : d_reg;
    ins_l[0] = le[0] ? lbl_q[0]  : l_reg;
    for (int i = 1; i < K; i++) begin
      if (le[i]) begin
        ins_d[i] = dist_q[i];
        ins_l[i] = lbl_q[i];
      end else if (le[i-1]) begin
        ins_d[i] = d_reg;
        ins_l[i] = l_reg;
      end else begin
        ins_d[i] = dist_q[i-1];
        ins_l[i] = lbl_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tx_q         <= '0;
      ty_q         <= '0;
      npts_q       <= '0;
      idx          <= '0;
      d_reg        <= '0;
      l_reg        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      nbr_cnt      <= '0;
      mem.mem_ren  <= 1'b0;
      mem.mem_addr <= '0;
      for (int i = 0; i < K; i++) begin
        dist_q[i] <= '1;
        lbl_q[i]  <= '0;
      end
    end else begin
      done        <= 1'b0;
      mem.mem_ren <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            nbr_cnt <= '0;
            for (int i = 0; i < K; i++) begin
              dist_q[i] <= '1;
              lbl_q[i]  <= '0;
            end
            if (n_points == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              tx_q         <= test_x;
              ty_q         <= test_y;
              npts_q       <= n_points;
              idx          <= '0;
              busy         <= 1'b1;
              mem.mem_ren  <= 1'b1;
              mem.mem_addr <= '0;
              state        <= FETCH;
            end
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          d_reg <= dist_calc;
          l_reg <= plbl;
          state <= INSERT;
        end
        INSERT: begin
          for (int i = 0; i < K; i++) begin
            dist_q[i] <= ins_d[i];
            lbl_q[i]  <= ins_l[i];
          end
          if (nbr_cnt < 4'(K)) nbr_cnt <= nbr_cnt + 4'd1;
          if ({1'b0, idx} == npts_q - 1'b1) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            idx          <= idx + 1'b1;
            mem.mem_ren  <= 1'b1;
            mem.mem_addr <= idx + 1'b1;
            state        <= FETCH;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < K; g++) begin : g_pack
    assign nbr_dist[g*(W+1) +: W+1]  = dist_q[g];
    assign nbr_label[g*LBL_W +: LBL_W] = lbl_q[g];
  end

endmodule

// File: tb/tb_knn_ctrl.sv
// Bench for knn_ctrl: random point sets against a selection-based nearest-K model,
// plus literal cases for ordering, ties, extremes, empty sets, busy starts and reset.
module tb_knn_ctrl;
  localparam int W = 32, K = 4, A_W = 8, LBL_W = 8, H = W / 2, DW = W + 1;

  logic                  clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic signed [H-1:0]   test_x = '0, test_y = '0;
  logic [A_W:0]          n_points = '0;
  logic                  busy, done;
  logic [3:0]            nbr_cnt;
  logic [K*DW-1:0]       nbr_dist;
  logic [K*LBL_W-1:0]    nbr_label;

  knn_ctrl_if #(.W(W), .A_W(A_W), .LBL_W(LBL_W)) mif ();

  knn_ctrl #(.W(W), .K(K), .A_W(A_W), .LBL_W(LBL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .test_x(test_x), .test_y(test_y),
    .n_points(n_points), .mem(mif), .busy(busy), .done(done), .nbr_cnt(nbr_cnt),
    .nbr_dist(nbr_dist), .nbr_label(nbr_label)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W+LBL_W-1:0] ram [2**A_W];
  always @(posedge clk)
    mif.mem_rdata <= mif.mem_ren ? ram[mif.mem_addr] : (W+LBL_W)'({$urandom(), $urandom()});

  int px [2**A_W], py [2**A_W], pl [2**A_W];
  int mode = 0;
  int start_cyc = 0, n_cur = 0, base_addr = 0, last_addr = 0;
  logic [DW-1:0]    exp_d [K];
  logic [LBL_W-1:0] exp_l [K];
  int exp_cnt = 0;
  int vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_pt(input int i, input int x, input int y, input int l);
    px[i] = x; py[i] = y; pl[i] = l;
    ram[i] = {LBL_W'(l), H'(y), H'(x)};
  endtask

  // nearest-K by repeated minimum selection; strict < keeps lower index first on ties
  task automatic build_model(input int n, input int tx, input int ty);
    longint d [2**A_W];
    bit     used [2**A_W];
    for (int i = 0; i < n; i++) begin
      d[i] = longint'(px[i] - tx) * longint'(px[i] - tx)
           + longint'(py[i] - ty) * longint'(py[i] - ty);
      used[i] = 1'b0;
    end
    for (int s = 0; s < K; s++) begin
      if (s < n) begin
        int b = -1;
        for (int i = 0; i < n; i++)
          if (!used[i] && (b < 0 || d[i] < d[b])) b = i;
        used[b]  = 1'b1;
        exp_d[s] = DW'(d[b]);
        exp_l[s] = LBL_W'(pl[b]);
      end else begin
        exp_d[s] = '1;
        exp_l[s] = '0;
      end
    end
    exp_cnt = (n < K) ? n : K;
  endtask

  always @(negedge clk) begin
    int k;
    int ea;
    if (mode == 0) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ren", mif.mem_ren, 0);
      chk("rst_addr", mif.mem_addr, 0);
      chk("rst_cnt", nbr_cnt, 0);
      for (int s = 0; s < K; s++) begin
        chk("rst_dist", nbr_dist[s*DW +: DW], {DW{1'b1}});
        chk("rst_label", nbr_label[s*LBL_W +: LBL_W], 0);
      end
    end else begin
      k = cyc - start_cyc + 1;
      if (n_cur > 0) ea = ((k - 1) / 3 < n_cur - 1) ? (k - 1) / 3 : n_cur - 1;
      else           ea = base_addr;
      chk("busy", busy, 64'(n_cur > 0 && k <= 3 * n_cur));
      chk("done", done, 64'(k == 3 * n_cur + 1));
      chk("mem_ren", mif.mem_ren, 64'(n_cur > 0 && k <= 3 * n_cur && (k % 3) == 1));
      chk("mem_addr", mif.mem_addr, 64'(ea));
      if (k >= 3 * n_cur + 1) begin
        chk("nbr_cnt", nbr_cnt, 64'(exp_cnt));
        for (int s = 0; s < K; s++) begin
          chk("nbr_dist", nbr_dist[s*DW +: DW], exp_d[s]);
          chk("nbr_label", nbr_label[s*LBL_W +: LBL_W], exp_l[s]);
        end
      end
    end
  end

  task automatic run(input int n, input int tx, input int ty, input int glitch_k, input int reset_k);
    @(posedge clk); #1;
    start = 1'b1; test_x = H'(tx); test_y = H'(ty); n_points = (A_W+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    base_addr = last_addr;
    if (n > 0) last_addr = n - 1;
    build_model(n, tx, ty);
    n_cur = n;
    mode = 1;
    test_x = H'($urandom); test_y = H'($urandom);
    n_points = (A_W+1)'($urandom_range(0, 2**A_W));
    for (int c = 1; c <= 3 * n + 3; c++) begin
      if (c == reset_k) begin
        rst_n = 1'b0; mode = 0; last_addr = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ren", mif.mem_ren, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      start = (c == glitch_k);
      if (start) begin
        test_x = H'($urandom); test_y = H'($urandom);
        n_points = (A_W+1)'($urandom_range(1, 2**A_W));
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2**A_W; i++) set_pt(i, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_slot0", nbr_dist[DW-1:0], 33'h1_FFFF_FFFF);
    chk("reset_slot3", nbr_dist[3*DW +: DW], 33'h1_FFFF_FFFF);

    set_pt(0, 3, 4, 8'h11); set_pt(1, 1, 1, 8'h12); set_pt(2, -2, 0, 8'h13);
    set_pt(3, 10, 0, 8'h14); set_pt(4, 0, 1, 8'h15);
    run(5, 0, 0, -1, -1);
    chk("basic_d0", nbr_dist[0*DW +: DW], 1);
    chk("basic_d1", nbr_dist[1*DW +: DW], 2);
    chk("basic_d2", nbr_dist[2*DW +: DW], 4);
    chk("basic_d3", nbr_dist[3*DW +: DW], 25);
    chk("basic_labels", nbr_label, 32'h1113_1215);
    chk("basic_cnt", nbr_cnt, 4);

    set_pt(0, 1, 0, 8'hA); set_pt(1, 0, 1, 8'hB); set_pt(2, -1, 0, 8'hC);
    run(3, 0, 0, -1, -1);
    chk("tie_d2", nbr_dist[2*DW +: DW], 1);
    chk("tie_labels", nbr_label[3*LBL_W-1:0], 24'h0C_0B_0A);
    chk("tie_cnt", nbr_cnt, 3);
    chk("tie_slot3", nbr_dist[3*DW +: DW], 33'h1_FFFF_FFFF);

    run(0, 5, 5, -1, -1);
    chk("empty_cnt", nbr_cnt, 0);

    set_pt(0, 32767, 32767, 8'h77);
    run(1, -32768, -32768, -1, -1);
    chk("extreme_d0", nbr_dist[DW-1:0], 33'h1_FFFC_0002);

    for (int i = 0; i < 8; i++) set_pt(i, $urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20, i + 1);
    run(5, 1, 1, 5, 8);
    run(6, -3, 2, 3 * 6 + 1, -1);
    run(4, 0, 0, 2, -1);

    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) begin
        if (r % 2 == 0) set_pt(i, $urandom_range(0, 6) - 3, $urandom_range(0, 6) - 3, $urandom_range(0, 255));
        else            set_pt(i, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, $urandom_range(0, 255));
      end
      if (r % 2 == 0) run(n, $urandom_range(0, 6) - 3, $urandom_range(0, 6) - 3, -1, -1);
      else            run(n, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, -1, -1);
    end

    for (int i = 0; i < 2**A_W; i++)
      set_pt(i, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, $urandom_range(0, 255));
    run(2**A_W, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
